// File: rtl/ens_vote_argmax_if.sv
// ens_vote_argmax_if: vote-in / result-out handshake bundle for ens_vote_argmax.
//   in_valid/in_ready/in_votes/in_last : one class-vote vector per beat, in_last closes frame
//   out_valid/out_ready/out_class/out_score : winning class and its vote count
//   out_tie : another class matched the winning score (VOTE_TIE_FLAG_EN builds only)
// Modports: slave = the voting block, master = the vote source / result sink.
interface ens_vote_if #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_ENS     = 4
);
  localparam int CNT_W = $clog2(NUM_ENS + 1);
  localparam int CLS_W = $clog2(NUM_CLASSES);

  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_CLASSES-1:0] in_votes;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [CLS_W-1:0]       out_class;
  logic [CNT_W-1:0]       out_score;
`ifdef VOTE_TIE_FLAG_EN
  logic                   out_tie;
`endif

  modport slave (
    input  in_valid, in_votes, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score
`ifdef VOTE_TIE_FLAG_EN
    , output out_tie
`endif
  );

  modport master (
    output in_valid, in_votes, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score
`ifdef VOTE_TIE_FLAG_EN
    , input out_tie
`endif
  );
endinterface

// File: rtl/ens_vote_argmax.sv
// ens_vote_argmax: per-class vote accumulator with sequential argmax.
//   Accepts one NUM_CLASSES-bit vote vector per beat, counts votes per class, and at
//   frame end (in_last or NUM_ENS beats) scans classes one per cycle to find the
//   winner (ties -> lowest index). Result is held on the out_* port until taken.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts any frame in flight)
//   vif  : ens_vote_if.slave -- vote input and result output handshakes
// Optional: define VOTE_TIE_FLAG_EN to add out_tie (another class equals best score).

// One per-class vote counter; clears when the result is taken.
module ens_vote_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end
endmodule

module ens_vote_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_ENS     = 4
) (
  input logic      clk,
  input logic      rst,
  ens_vote_if.slave vif
);
  localparam int CNT_W = $clog2(NUM_ENS + 1);
  localparam int CLS_W = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  state_t                            state_q, state_d;
  logic                              rdy_q;     // low during reset, high from first clock after
  logic [CNT_W-1:0]                  ens_cnt;
  logic [CLS_W-1:0]                  idx;
  logic [CNT_W-1:0]                  best_score;
  logic [CLS_W-1:0]                  best_class;
  logic                              out_vld;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]                  cur;
  logic                              acc, take, frame_end, scan_done;

  assign acc       = (state_q == ACCUM) && rdy_q && vif.in_valid;
  assign take      = (state_q == HOLD) && out_vld && vif.out_ready;
  assign frame_end = vif.in_last || (ens_cnt == CNT_W'(NUM_ENS - 1));
  assign scan_done = (idx == CLS_W'(NUM_CLASSES - 1));
  assign cur       = cnt[idx];

  // per-class counters
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
    ens_vote_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (take),
      .inc (acc & vif.in_votes[k]),
      .cnt (cnt[k])
    );
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (acc && frame_end) state_d = SCAN;
      SCAN:  if (scan_done)        state_d = HOLD;
      HOLD:  if (take)             state_d = ACCUM;
      default:                     state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      ens_cnt <= '0;
      idx     <= '0;
      out_vld <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (take)     ens_cnt <= '0;
      else if (acc) ens_cnt <= ens_cnt + CNT_W'(1);
      idx <= (state_q == SCAN && !scan_done) ? idx + CLS_W'(1) : '0;
      // One cycle in HOLD before raising valid keeps the last scan result registered
      // ahead of the port, giving NUM_CLASSES+1 cycles from last beat to valid.
      if (take)                 out_vld <= 1'b0;
      else if (state_q == HOLD) out_vld <= 1'b1;
    end
  end

  // argmax scan: strict > so ties keep the lower index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score <= '0;
      best_class <= '0;
    end else if (state_q == SCAN) begin
      if (idx == '0) begin
        best_score <= cur;
        best_class <= '0;
      end else if (cur > best_score) begin
        best_score <= cur;
        best_class <= idx;
      end
    end
  end

`ifdef VOTE_TIE_FLAG_EN
  logic tie_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tie_q <= 1'b0;
    else if (state_q == SCAN) begin
      if (idx == '0)               tie_q <= 1'b0;
      else if (cur > best_score)   tie_q <= 1'b0;
      else if (cur == best_score)  tie_q <= 1'b1;
    end
  end
  assign vif.out_tie = tie_q;
`endif

  assign vif.in_ready  = rdy_q && (state_q == ACCUM);
  assign vif.out_valid = out_vld;
  assign vif.out_class = best_class;
  assign vif.out_score = best_score;
endmodule
